edge_detect_multi: RTL and testbench

Parametrised multi-channel edge detector: generalises the single-channel rising-edge cell to CHANNELS asynchronous inputs with per-channel synchroniser, selectable edge mode, single-cycle event pulses, sticky event flags and an optional saturating event counter. It sits between raw `io_in` pins and downstream logic in a TinyTapeout design, giving clean, clock-domain-safe event strobes.

---
 rtl/edge_detect_multi_if.sv | 26 ++
 rtl/edge_detect_multi.sv | 85 ++++++++
 tb/tb_edge_detect_multi.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_multi_if.sv
// Bundle of the detector's pin-side inputs and event-side outputs.
// All signals are level or single-cycle strobes; there is no valid/ready handshake.
interface edge_detect_multi_if #(
  parameter int CHANNELS = 4,
  parameter int COUNT_W  = 8
);
  logic [CHANNELS-1:0]   sig_in;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   flag_clr;
  logic                  count_clr;
  logic [CHANNELS-1:0]   pulse;
  logic [CHANNELS-1:0]   flag;
  logic                  any_pulse;
  logic [COUNT_W-1:0]    count;
  logic                  armed;

  modport master (
    output sig_in, mode, flag_clr, count_clr,
    input  pulse, flag, any_pulse, count, armed
  );

  modport slave (
    input  sig_in, mode, flag_clr, count_clr,
    output pulse, flag, any_pulse, count, armed
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised edge detector with sticky flags and warm-up arming.
// Optional saturating event counter is built when EDGE_DETECT_COUNT_EN is defined.
module edge_detect_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  edge_detect_multi_if.slave bus
);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic                any_q;
  logic [WARM_W-1:0]   warm_q;
  logic                armed_q;
  logic [CHANNELS-1:0] synced, rise, fall, event_d;

  always_comb begin
    synced  = sync_q[SYNC_STAGES-1];
    rise    = synced & ~prev_q;
    fall    = ~synced & prev_q;
    event_d = '0;
    // Mode only gates the edge terms, so changing it can never create an event.
    for (int i = 0; i < CHANNELS; i++) begin
      event_d[i] = armed_q & ((bus.mode[2*i] & rise[i]) | (bus.mode[2*i+1] & fall[i]));
    end
    flag_d = event_d | (flag_q & ~bus.flag_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      any_q   <= 1'b0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q  <= synced;
      pulse_q <= event_d;
      flag_q  <= flag_d;
      any_q   <= |event_d;
      // Arming waits until the chain and prev flop hold post-reset samples.
      if (!armed_q) begin
        if (warm_q == WARM_LAST) armed_q <= 1'b1;
        else                     warm_q  <= warm_q + WARM_W'(1);
      end
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.flag      = flag_q;
  assign bus.any_pulse = any_q;
  assign bus.armed     = armed_q;

`ifdef EDGE_DETECT_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (bus.count_clr)                    count_d = '0;
    else if ((|event_d) && (count_q != '1)) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.count = count_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = bus.count_clr;
  assign bus.count        = '0;
`endif
endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed plus randomized bench for edge_detect_multi against a sample-history model.
module tb_edge_detect_multi;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  edge_detect_multi_if #(.CHANNELS(CH), .COUNT_W(CW)) bus ();

  edge_detect_multi #(.CHANNELS(CH), .SYNC_STAGES(S), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: history of input samples taken at each edge since reset release.
  logic [CH-1:0] hist [$];
  int            edges;
  logic [CH-1:0] m_pulse, m_flag;
  logic          m_any, m_armed;
  int            m_count;

  function automatic logic [CH-1:0] samp(input int k);
    if (k < 1) return '0;
    return hist[k-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    edges   = 0;
    m_pulse = '0;
    m_flag  = '0;
    m_any   = 1'b0;
    m_armed = 1'b0;
    m_count = 0;
  endtask

  task automatic model_edge(input logic [CH-1:0] sig, input logic [2*CH-1:0] md,
                            input logic [CH-1:0] fc, input logic cc);
    logic [CH-1:0] ev, s, p;
    edges++;
    hist.push_back(sig);
    ev = '0;
    // Armed before this edge means at least S+1 prior edges since release.
    if (edges - 1 >= S + 1) begin
      s = samp(edges - S);
      p = samp(edges - S - 1);
      for (int i = 0; i < CH; i++) begin
        if (s[i] != p[i]) ev[i] = s[i] ? md[2*i] : md[2*i+1];
      end
    end
    m_pulse = ev;
    m_any   = (ev != 0);
    for (int i = 0; i < CH; i++) begin
      if (ev[i])      m_flag[i] = 1'b1;
      else if (fc[i]) m_flag[i] = 1'b0;
    end
`ifdef EDGE_DETECT_COUNT_EN
    if (cc)                           m_count = 0;
    else if (ev != 0 && m_count < CMAX) m_count = m_count + 1;
`endif
    m_armed = (edges >= S + 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic check_all();
    chk("pulse",     32'(bus.pulse),     32'(m_pulse));
    chk("flag",      32'(bus.flag),      32'(m_flag));
    chk("any_pulse", 32'(bus.any_pulse), 32'(m_any));
    chk("count",     32'(bus.count),     32'(m_count));
    chk("armed",     32'(bus.armed),     32'(m_armed));
  endtask

  // Drive at the negedge, model the following posedge, check at the next negedge.
  task automatic cycle(input logic [CH-1:0] sig, input logic [2*CH-1:0] md,
                       input logic [CH-1:0] fc, input logic cc);
    bus.sig_in    = sig;
    bus.mode      = md;
    bus.flag_clr  = fc;
    bus.count_clr = cc;
    @(posedge clk);
    model_edge(sig, md, fc, cc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_pulse"}, 32'(bus.pulse),     32'd0);
    chk({tag, "_flag"},  32'(bus.flag),      32'd0);
    chk({tag, "_any"},   32'(bus.any_pulse), 32'd0);
    chk({tag, "_count"}, 32'(bus.count),     32'd0);
    chk({tag, "_armed"}, 32'(bus.armed),     32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [CH-1:0]   rs;
    logic [2*CH-1:0] rm;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.sig_in    = 4'hF;
    bus.mode      = 8'h55;
    bus.flag_clr  = '0;
    bus.count_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Inputs already high at release: arming only, no events.
    for (int n = 0; n < 6; n++) cycle(4'hF, 8'h55, 4'h0, 1'b0);
    for (int n = 0; n < 5; n++) cycle(4'h0, 8'h01, 4'h0, 1'b0);

    // Ch0 rising only: 0->1 pulses, 1->0 silent.
    for (int n = 0; n < 5; n++) cycle(4'h1, 8'h01, 4'h0, 1'b0);
    for (int n = 0; n < 5; n++) cycle(4'h0, 8'h01, 4'h0, 1'b0);

    // Ch1 both edges, ch2 falling: 2-cycle high pulse on both.
    for (int n = 0; n < 2; n++) cycle(4'h6, 8'h2D, 4'h0, 1'b0);
    for (int n = 0; n < 6; n++) cycle(4'h0, 8'h2D, 4'h0, 1'b0);

    // Flag clear coinciding with a new ch0 event, then clear alone.
    cycle(4'h0, 8'h01, 4'hF, 1'b0);
    cycle(4'h1, 8'h01, 4'h0, 1'b0);
    cycle(4'h1, 8'h01, 4'h0, 1'b0);
    cycle(4'h1, 8'h01, 4'h1, 1'b0);
    cycle(4'h1, 8'h01, 4'h1, 1'b0);
    cycle(4'h1, 8'h01, 4'h0, 1'b0);

    // Saturation, clear against a simultaneous event, all channels at once.
    for (int n = 0; n < 6; n++) begin
      cycle(4'h0, 8'h03, 4'h0, 1'b0);
      cycle(4'h0, 8'h03, 4'h0, 1'b0);
      cycle(4'h1, 8'h03, 4'h0, 1'b0);
      cycle(4'h1, 8'h03, 4'h0, 1'b0);
    end
    cycle(4'h0, 8'h03, 4'h0, 1'b0);
    cycle(4'h0, 8'h03, 4'h0, 1'b0);
    cycle(4'h0, 8'h03, 4'h0, 1'b1);
    cycle(4'h0, 8'hFF, 4'h0, 1'b0);
    for (int n = 0; n < 4; n++) cycle(4'hF, 8'hFF, 4'h0, 1'b0);
    for (int n = 0; n < 4; n++) cycle(4'h0, 8'hFF, 4'h0, 1'b0);

    // Randomized traffic.
    rm = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      if ((n % 32) == 0) rm = 8'($urandom);
      rs = 4'($urandom_range(0, 15));
      cycle(rs, rm,
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            ($urandom_range(0, 15) == 0));
    end

    // Reset during warm-up, then during a live pulse.
    do_reset("rst_warm");
    cycle(4'hF, 8'hFF, 4'h0, 1'b0);
    cycle(4'hF, 8'hFF, 4'h0, 1'b0);
    do_reset("rst_warm2");
    for (int n = 0; n < 6; n++) cycle(4'hF, 8'hFF, 4'h0, 1'b0);
    cycle(4'h0, 8'hFF, 4'h0, 1'b0);
    cycle(4'h0, 8'hFF, 4'h0, 1'b0);
    cycle(4'h0, 8'hFF, 4'h0, 1'b0);
    chk("pulse_before_reset", 32'(bus.pulse), 32'hF);
    do_reset("rst_pulse");
    for (int n = 0; n < 8; n++) cycle(4'(n), 8'hFF, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
